// File: rtl/exc_pc_if.sv
// Trap/return handshake between the main control FSM and the exception PC sequencer.
// master: main control FSM side; slave: exc_pc_ctrl.
interface exc_pc_if;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic        eret;
  logic [31:0] pc_atual;
  logic [31:0] epc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [2:0]  pc_sel;
  logic        pc_we;
  logic        busy;
  logic [1:0]  cause;

  modport master (
    output exc_opcode, exc_ovf, exc_div0, eret, pc_atual,
    input  epc, mem_addr, mem_rd, pc_sel, pc_we, busy, cause
  );

  modport slave (
    input  exc_opcode, exc_ovf, exc_div0, eret, pc_atual,
    output epc, mem_addr, mem_rd, pc_sel, pc_we, busy, cause
  );
endinterface

// File: rtl/exc_pc_ctrl.sv
// Exception/return sequencer: saves EPC, reads the handler vector from memory, loads the PC.
// Define EXC_CAUSE_EN to build the trap-cause register; otherwise cause reads 2'b00.
module exc_pc_ctrl #(
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255,
  parameter int unsigned MEM_LAT    = 1
) (
  input logic     clk,
  input logic     reset_n,
  exc_pc_if.slave bus
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SAVE  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_RET   = 3'd4;

  localparam logic [2:0] SEL_MEM  = 3'b000;
  localparam logic [2:0] SEL_HOLD = 3'b011;
  localparam logic [2:0] SEL_EPC  = 3'b101;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       code_q, code_d;
  logic [31:0]      vec_addr;
  logic [31:0]      epc_q, mem_addr_q;
  logic [2:0]       pc_sel_q, pc_sel_d;
  logic             mem_rd_q, mem_rd_d;
  logic             pc_we_q, pc_we_d;
  logic             busy_q, busy_d;
  logic             take_exc;

  assign take_exc = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;

  // Cause code of the highest-priority pending trap (opcode > ovf > div0)
  always_comb begin
    code_d = 2'b00;
    if (bus.exc_opcode)    code_d = 2'b01;
    else if (bus.exc_ovf)  code_d = 2'b10;
    else if (bus.exc_div0) code_d = 2'b11;
  end

  always_comb begin
    vec_addr = VEC_OPCODE;
    case (code_q)
      2'b10:   vec_addr = VEC_OVF;
      2'b11:   vec_addr = VEC_DIV0;
      default: vec_addr = VEC_OPCODE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus next values of the registered outputs, decoded from the next state
  always_comb begin
    state_d  = state_q;
    pc_sel_d = SEL_HOLD;
    pc_we_d  = 1'b0;
    mem_rd_d = 1'b0;
    busy_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (take_exc)      state_d = S_SAVE;
        else if (bus.eret) state_d = S_RET;
      end
      S_SAVE:  state_d = S_FETCH;
      S_FETCH: if (cnt_q == '0) state_d = S_LOAD;
      S_LOAD:  state_d = S_IDLE;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_IDLE:  busy_d = 1'b0;
      S_FETCH: mem_rd_d = 1'b1;
      S_LOAD: begin
        pc_sel_d = SEL_MEM;
        pc_we_d  = 1'b1;
      end
      S_RET: begin
        pc_sel_d = SEL_EPC;
        pc_we_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q     <= 2'b00;
      cnt_q      <= '0;
      epc_q      <= 32'd0;
      mem_addr_q <= 32'd0;
      pc_sel_q   <= SEL_HOLD;
      pc_we_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && take_exc) code_q <= code_d;
      if (state_q == S_SAVE) begin
        epc_q <= bus.pc_atual - 32'd4;
        cnt_q <= CNT_W'(MEM_LAT - 1);
      end else if (state_q == S_FETCH && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // mem_addr only changes while fetching and holds afterwards
      if (state_d == S_FETCH) mem_addr_q <= vec_addr;
      pc_sel_q <= pc_sel_d;
      pc_we_q  <= pc_we_d;
      mem_rd_q <= mem_rd_d;
      busy_q   <= busy_d;
    end
  end

`ifdef EXC_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cause_q <= 2'b00;
    else if (state_q == S_SAVE)  cause_q <= code_q;
  end

  assign bus.cause = cause_q;
`else
  assign bus.cause = 2'b00;
`endif

  assign bus.epc      = epc_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.pc_sel   = pc_sel_q;
  assign bus.pc_we    = pc_we_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_exc_pc_ctrl.sv
// Bench for exc_pc_ctrl: table-driven trap/eret vectors checked by a scoreboard on each PC write.
module tb_exc_pc_ctrl;

  localparam int unsigned LAT = 1;
`ifdef EXC_CAUSE_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   fails;
  int   busy_cnt;
  int   rd_cnt;

  exc_pc_if bus ();

  exc_pc_ctrl #(.MEM_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        op;
    logic        ovf;
    logic        dz;
    logic        er;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [31:0] epc;
    logic [31:0] addr;
    logic [1:0]  cause;
    int          lat;
    int          rd;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] epc;
    logic [31:0] addr;
    logic [1:0]  cause;
    int          lat;
    int          rd;
    int          issue;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void chk_reset_vals(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_pc_sel"}, 32'(bus.pc_sel), 32'd3);
    chk({tag, "_pc_we"}, 32'(bus.pc_we), 32'd0);
    chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_epc"}, bus.epc, 32'd0);
    chk({tag, "_cause"}, 32'(bus.cause), 32'd0);
  endfunction

  // Monitor: every PC write pops one expected record
  always @(negedge clk) begin
    sb_t e;
    if (!reset_n) begin
      busy_cnt = 0;
      rd_cnt   = 0;
    end else begin
      if (bus.busy)   busy_cnt++;
      if (bus.mem_rd) rd_cnt++;
      if (bus.pc_we) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_pc_we actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("pc_sel", 32'(bus.pc_sel), 32'(e.sel));
          chk("epc", bus.epc, e.epc);
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("cause", 32'(bus.cause), 32'(e.cause));
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("mem_rd_cycles", 32'(rd_cnt), 32'(e.rd));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt = 0;
        rd_cnt   = 0;
      end
    end
  end

  task automatic drain(string name);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      sb.delete();
    end
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic apply(vec_t v, string name);
    sb_t e;
    @(negedge clk);
    bus.exc_opcode = v.op;
    bus.exc_ovf    = v.ovf;
    bus.exc_div0   = v.dz;
    bus.eret       = v.er;
    bus.pc_atual   = v.pc;
    e.sel   = v.sel;
    e.epc   = v.epc;
    e.addr  = v.addr;
    e.cause = CAUSE_EN ? v.cause : 2'b00;
    e.lat   = v.lat;
    e.rd    = v.rd;
    e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.exc_opcode = 1'b0;
    bus.exc_ovf    = 1'b0;
    bus.exc_div0   = 1'b0;
    bus.eret       = 1'b0;
    drain(name);
  endtask

  task automatic wait_mem_rd(string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.mem_rd;
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL %s_no_fetch actual=0 required=1", name);
    end
  endtask

  initial begin
    vec_t v;
    cyc = 0; checks = 0; fails = 0; busy_cnt = 0; rd_cnt = 0;
    reset_n = 1'b0;
    bus.exc_opcode = 1'b0;
    bus.exc_ovf    = 1'b0;
    bus.exc_div0   = 1'b0;
    bus.eret       = 1'b0;
    bus.pc_atual   = 32'd0;

    //          op    ovf   dz    er    pc            sel     epc           addr    cause lat      rd
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40,       3'b000, 32'h3C,       32'd254, 2'd2, 2+LAT, LAT};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40,       3'b101, 32'h3C,       32'd254, 2'd2, 1,     0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h100,      3'b000, 32'hFC,       32'd253, 2'd1, 2+LAT, LAT};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 32'hFFFFFFFC, 32'd255, 2'd3, 2+LAT, LAT};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1004,     3'b000, 32'h1000,     32'd254, 2'd2, 2+LAT, LAT};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h80,       3'b000, 32'h7C,       32'd254, 2'd2, 2+LAT, LAT};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h500,      3'b101, 32'h7C,       32'd254, 2'd2, 1,     0};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("idle");

    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // A div0 request arriving during FETCH must be dropped
    v = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 3'b000, 32'h1FC, 32'd254, 2'd2, 2+LAT, LAT};
    fork
      apply(v, "busy_ignore");
      begin
        wait_mem_rd("busy_ignore");
        bus.exc_div0 = 1'b1;
        @(negedge clk);
        bus.exc_div0 = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("busy_ignore_idle", 32'(bus.busy), 32'd0);
    chk("busy_ignore_addr", bus.mem_addr, 32'd254);

    // Reset pulsed mid-FETCH aborts the trap without a PC write
    @(negedge clk);
    bus.exc_ovf  = 1'b1;
    bus.pc_atual = 32'h300;
    @(negedge clk);
    bus.exc_ovf = 1'b0;
    wait_mem_rd("abort");
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("abort_async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("abort_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
